// File: rtl/seq_tx_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
package seq_tx_pkg;

   // Transmitter FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } tx_state_t;

   // Run length flagged by the downstream detector
   localparam int RUN_LEN_DEFAULT = 4;

endpackage

// File: rtl/seq_run_tracker.sv
// Tracks runs of equal valid bits and flags when RUN_LEN equal bits in a row
// have been seen, including the bit presented this cycle. run_hit is
// registered so it lines up with a registered copy of the bit stream.
module seq_run_tracker
   import seq_tx_pkg::*;
#(
   parameter int RUN_LEN = RUN_LEN_DEFAULT
) (
   input  logic Clock,
   input  logic Reset,
   input  logic clear,
   input  logic bit_valid,
   input  logic data_bit,
   output logic run_hit
);

   localparam int CNT_W = $clog2(RUN_LEN + 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic             prev;
   logic             hit_nx;

   // Next run count: a count of 0 marks "no valid bit since clear"
   always_comb begin
      cnt_nx = cnt;
      hit_nx = 1'b0;
      if (bit_valid) begin
         if (clear || (cnt == '0) || (data_bit != prev)) begin
            cnt_nx = CNT_W'(1);
         end else if (cnt != CNT_W'(RUN_LEN)) begin
            cnt_nx = cnt + CNT_W'(1);
         end
         hit_nx = (cnt_nx == CNT_W'(RUN_LEN));
      end else if (clear) begin
         cnt_nx = '0;
      end
   end

   // Run counter, last valid bit and registered hit flag
   always_ff @(posedge Clock) begin
      if (Reset) begin
         cnt     <= '0;
         prev    <= 1'b0;
         run_hit <= 1'b0;
      end else begin
         cnt     <= cnt_nx;
         run_hit <= hit_nx;
         if (bit_valid) begin
            prev <= data_bit;
         end
      end
   end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: serializes a latched pattern LSB-first, one bit
// per clock, with optional repeat separated by idle gap cycles. ExpectZ models
// the run-length detector's response, aligned with W.
module seq_pattern_tx
   import seq_tx_pkg::*;
#(
   parameter int MAX_LEN    = 16,
   parameter int LEN_W      = $clog2(MAX_LEN + 1),
   parameter int RUN_LEN    = RUN_LEN_DEFAULT,
   parameter int GAP_CYCLES = 2
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Start,
   input  logic [MAX_LEN-1:0] Pattern,
   input  logic [LEN_W-1:0]   Length,
   input  logic               Repeat,
   input  logic               Stop,
   output logic               Busy,
   output logic               W,
   output logic               WValid,
   output logic               Done,
   output logic               ExpectZ
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   tx_state_t          state;
   tx_state_t          state_nx;
   logic [LEN_W-1:0]   idx;
   logic [LEN_W-1:0]   idx_nx;
   logic [GAP_W-1:0]   gap_cnt;
   logic [GAP_W-1:0]   gap_nx;
   logic [MAX_LEN-1:0] pat_q;
   logic [MAX_LEN-1:0] sh_q;
   logic [MAX_LEN-1:0] sh_nx;
   logic [LEN_W-1:0]   len_q;
   logic               rep_q;
   logic [LEN_W-1:0]   len_clamped;
   logic               latch;
   logic               w_nx;
   logic               wv_nx;
   logic               done_nx;

   // Next state, next bit and output values; outputs are registered below
   always_comb begin
      state_nx    = state;
      idx_nx      = idx;
      gap_nx      = gap_cnt;
      sh_nx       = sh_q;
      latch       = 1'b0;
      w_nx        = 1'b0;
      wv_nx       = 1'b0;
      done_nx     = 1'b0;
      len_clamped = (Length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : Length;
      case (state)
         IDLE: begin
            // Stop has no meaning here; Start wins when both are high
            if (Start && (Length != '0)) begin
               latch    = 1'b1;
               state_nx = SEND;
               idx_nx   = '0;
               sh_nx    = Pattern;
               w_nx     = Pattern[0];
               wv_nx    = 1'b1;
            end
         end
         SEND: begin
            if (Stop) begin
               state_nx = IDLE;
            end else if (idx == (len_q - LEN_W'(1))) begin
               if (rep_q) begin
                  state_nx = GAP;
                  gap_nx   = '0;
               end else begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
               end
            end else begin
               idx_nx = idx + LEN_W'(1);
               sh_nx  = sh_q >> 1;
               w_nx   = sh_q[1];
               wv_nx  = 1'b1;
            end
         end
         GAP: begin
            if (Stop) begin
               state_nx = IDLE;
            end else if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
               state_nx = SEND;
               idx_nx   = '0;
               sh_nx    = pat_q;
               w_nx     = pat_q[0];
               wv_nx    = 1'b1;
            end else begin
               gap_nx = gap_cnt + GAP_W'(1);
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Control state and registered outputs
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         idx     <= '0;
         gap_cnt <= '0;
         Busy    <= 1'b0;
         W       <= 1'b0;
         WValid  <= 1'b0;
         Done    <= 1'b0;
      end else begin
         state   <= state_nx;
         idx     <= idx_nx;
         gap_cnt <= gap_nx;
         Busy    <= (state_nx != IDLE);
         W       <= w_nx;
         WValid  <= wv_nx;
         Done    <= done_nx;
      end
   end

   // Pattern, length and repeat captured at an accepted Start; shift copy walks the bits
   always_ff @(posedge Clock) begin
      sh_q <= sh_nx;
      if (latch) begin
         pat_q <= Pattern;
         len_q <= len_clamped;
         rep_q <= Repeat;
      end
   end

   seq_run_tracker #(
      .RUN_LEN (RUN_LEN)
   ) u_run (
      .Clock     (Clock),
      .Reset     (Reset),
      .clear     (latch),
      .bit_valid (wv_nx),
      .data_bit  (w_nx),
      .run_hit   (ExpectZ)
   );

endmodule
